// File: rtl/wb_scoreboard_pkg.sv
// Shared types and sizing for the in-order completion scoreboard.
// The size define is shared with the issue and writeback stages.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 3
`endif

package wb_scoreboard_pkg;

  localparam int IDX_W = `SCOREBOARD_SIZE_WIDTH;
  localparam int SW    = IDX_W + 1;
  localparam int DEPTH = 1 << IDX_W;

  typedef logic [SW-1:0]    sid_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] value;
  } entry_t;

  function automatic idx_t sid_idx(input sid_t sid);
    return sid[IDX_W-1:0];
  endfunction

  // A stale sid that aliases a live slot differs in its wrap bit, so it falls outside the window.
  function automatic logic sid_in_window(input sid_t sid, input sid_t head, input sid_t count);
    sid_t offset;
    offset = sid - head;
    return offset < count;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// In-order completion scoreboard: allocates sids at issue, absorbs two
// writebacks per cycle and retires up to two completed entries in program order.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue0_valid_i,
  input  logic          issue1_valid_i,
  input  logic [4:0]    issue0_rd_i,
  input  logic [4:0]    issue1_rd_i,
  input  logic          issue0_wen_i,
  input  logic          issue1_wen_i,
  output logic          alloc_ready_o,
  output logic [SW-1:0] issue0_sid_o,
  output logic [SW-1:0] issue1_sid_o,
  input  logic          inst0_wb_valid_i,
  input  logic          inst1_wb_valid_i,
  input  logic [SW-1:0] inst0_wb_sid_i,
  input  logic [SW-1:0] inst1_wb_sid_i,
  input  logic [63:0]   inst0_wb_value_i,
  input  logic [63:0]   inst1_wb_value_i,
  input  logic          flush_i,
  output logic [31:0]   rd_busy_o,
  output logic          commit0_valid_o,
  output logic          commit1_valid_o,
  output logic          commit0_wen_o,
  output logic          commit1_wen_o,
  output logic [4:0]    commit0_rd_o,
  output logic [4:0]    commit1_rd_o,
  output logic [63:0]   commit0_value_o,
  output logic [63:0]   commit1_value_o,
  output logic [SW-1:0] commit0_sid_o,
  output logic [SW-1:0] commit1_sid_o
);

  entry_t entries_q [DEPTH];
  entry_t entries_d [DEPTH];
  sid_t   head_q, head_d, tail_q, tail_d;

  logic        c0_valid_q, c0_valid_d, c1_valid_q, c1_valid_d;
  logic        c0_wen_q, c0_wen_d, c1_wen_q, c1_wen_d;
  logic [4:0]  c0_rd_q, c0_rd_d, c1_rd_q, c1_rd_d;
  logic [63:0] c0_value_q, c0_value_d, c1_value_q, c1_value_d;
  sid_t        c0_sid_q, c0_sid_d, c1_sid_q, c1_sid_d;

  sid_t        count_w, head1_w;
  logic [SW:0] free_w;
  logic        commit0_w, commit1_w, wb0_hit_w, wb1_hit_w;
  entry_t      head_e_w, head1_e_w, wb0_e_w, wb1_e_w;

  assign count_w       = tail_q - head_q;
  assign free_w        = (SW+1)'(DEPTH) - {1'b0, count_w};
  assign alloc_ready_o = free_w >= (SW+1)'(2);
  assign head1_w       = head_q + sid_t'(1);
  assign issue0_sid_o  = tail_q;
  assign issue1_sid_o  = issue0_valid_i ? sid_t'(tail_q + sid_t'(1)) : tail_q;

  assign head_e_w  = entries_q[sid_idx(head_q)];
  assign head1_e_w = entries_q[sid_idx(head1_w)];
  assign commit0_w = head_e_w.valid & head_e_w.done;
  assign commit1_w = commit0_w & head1_e_w.valid & head1_e_w.done;

  assign wb0_e_w   = entries_q[sid_idx(inst0_wb_sid_i)];
  assign wb1_e_w   = entries_q[sid_idx(inst1_wb_sid_i)];
  assign wb0_hit_w = inst0_wb_valid_i & sid_in_window(inst0_wb_sid_i, head_q, count_w)
                     & wb0_e_w.valid & ~wb0_e_w.done;
  assign wb1_hit_w = inst1_wb_valid_i & sid_in_window(inst1_wb_sid_i, head_q, count_w)
                     & wb1_e_w.valid & ~wb1_e_w.done;

  // Commit, writeback and allocation touch disjoint slots, so their order here only matters for port 1 overriding port 0.
  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    c0_valid_d = 1'b0;
    c0_wen_d   = 1'b0;
    c0_rd_d    = '0;
    c0_value_d = '0;
    c0_sid_d   = '0;
    c1_valid_d = 1'b0;
    c1_wen_d   = 1'b0;
    c1_rd_d    = '0;
    c1_value_d = '0;
    c1_sid_d   = '0;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
      tail_d = head_q;
    end else begin
      if (commit0_w) begin
        c0_valid_d = 1'b1;
        c0_wen_d   = head_e_w.wen & (head_e_w.rd != 5'd0);
        c0_rd_d    = head_e_w.rd;
        c0_value_d = head_e_w.value;
        c0_sid_d   = head_q;
        entries_d[sid_idx(head_q)] = '0;
      end
      if (commit1_w) begin
        c1_valid_d = 1'b1;
        c1_wen_d   = head1_e_w.wen & (head1_e_w.rd != 5'd0);
        c1_rd_d    = head1_e_w.rd;
        c1_value_d = head1_e_w.value;
        c1_sid_d   = head1_w;
        entries_d[sid_idx(head1_w)] = '0;
      end
      head_d = head_q + sid_t'(commit0_w) + sid_t'(commit1_w);
      if (wb0_hit_w) begin
        entries_d[sid_idx(inst0_wb_sid_i)].done  = 1'b1;
        entries_d[sid_idx(inst0_wb_sid_i)].value = inst0_wb_value_i;
      end
      if (wb1_hit_w) begin
        entries_d[sid_idx(inst1_wb_sid_i)].done  = 1'b1;
        entries_d[sid_idx(inst1_wb_sid_i)].value = inst1_wb_value_i;
      end
      if (alloc_ready_o) begin
        if (issue0_valid_i)
          entries_d[sid_idx(issue0_sid_o)] = '{valid: 1'b1, done: 1'b0, wen: issue0_wen_i,
                                               rd: issue0_rd_i, value: 64'd0};
        if (issue1_valid_i)
          entries_d[sid_idx(issue1_sid_o)] = '{valid: 1'b1, done: 1'b0, wen: issue1_wen_i,
                                               rd: issue1_rd_i, value: 64'd0};
        tail_d = tail_q + sid_t'(issue0_valid_i) + sid_t'(issue1_valid_i);
      end
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entries_q[i].valid && entries_q[i].wen) rd_busy_o[entries_q[i].rd] = 1'b1;
    rd_busy_o[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      c0_valid_q <= 1'b0;
      c0_wen_q   <= 1'b0;
      c0_rd_q    <= '0;
      c0_value_q <= '0;
      c0_sid_q   <= '0;
      c1_valid_q <= 1'b0;
      c1_wen_q   <= 1'b0;
      c1_rd_q    <= '0;
      c1_value_q <= '0;
      c1_sid_q   <= '0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      c0_valid_q <= c0_valid_d;
      c0_wen_q   <= c0_wen_d;
      c0_rd_q    <= c0_rd_d;
      c0_value_q <= c0_value_d;
      c0_sid_q   <= c0_sid_d;
      c1_valid_q <= c1_valid_d;
      c1_wen_q   <= c1_wen_d;
      c1_rd_q    <= c1_rd_d;
      c1_value_q <= c1_value_d;
      c1_sid_q   <= c1_sid_d;
    end
  end

  assign commit0_valid_o = c0_valid_q;
  assign commit0_wen_o   = c0_wen_q;
  assign commit0_rd_o    = c0_rd_q;
  assign commit0_value_o = c0_value_q;
  assign commit0_sid_o   = c0_sid_q;
  assign commit1_valid_o = c1_valid_q;
  assign commit1_wen_o   = c1_wen_q;
  assign commit1_rd_o    = c1_rd_q;
  assign commit1_value_o = c1_value_q;
  assign commit1_sid_o   = c1_sid_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: a queue-based program-order model predicts
// retirements, and a separate monitor pops and compares them as the DUT commits.
module tb_wb_scoreboard;
  import wb_scoreboard_pkg::*;

  localparam int SIDS = 1 << SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue0_valid_i = 1'b0, issue1_valid_i = 1'b0;
  logic [4:0]    issue0_rd_i = '0, issue1_rd_i = '0;
  logic          issue0_wen_i = 1'b0, issue1_wen_i = 1'b0;
  logic          alloc_ready_o;
  logic [SW-1:0] issue0_sid_o, issue1_sid_o;
  logic          inst0_wb_valid_i = 1'b0, inst1_wb_valid_i = 1'b0;
  logic [SW-1:0] inst0_wb_sid_i = '0, inst1_wb_sid_i = '0;
  logic [63:0]   inst0_wb_value_i = '0, inst1_wb_value_i = '0;
  logic          flush_i = 1'b0;
  logic [31:0]   rd_busy_o;
  logic          commit0_valid_o, commit1_valid_o, commit0_wen_o, commit1_wen_o;
  logic [4:0]    commit0_rd_o, commit1_rd_o;
  logic [63:0]   commit0_value_o, commit1_value_o;
  logic [SW-1:0] commit0_sid_o, commit1_sid_o;

  wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue0_valid_i(issue0_valid_i), .issue1_valid_i(issue1_valid_i),
    .issue0_rd_i(issue0_rd_i), .issue1_rd_i(issue1_rd_i),
    .issue0_wen_i(issue0_wen_i), .issue1_wen_i(issue1_wen_i),
    .alloc_ready_o(alloc_ready_o), .issue0_sid_o(issue0_sid_o), .issue1_sid_o(issue1_sid_o),
    .inst0_wb_valid_i(inst0_wb_valid_i), .inst1_wb_valid_i(inst1_wb_valid_i),
    .inst0_wb_sid_i(inst0_wb_sid_i), .inst1_wb_sid_i(inst1_wb_sid_i),
    .inst0_wb_value_i(inst0_wb_value_i), .inst1_wb_value_i(inst1_wb_value_i),
    .flush_i(flush_i), .rd_busy_o(rd_busy_o),
    .commit0_valid_o(commit0_valid_o), .commit1_valid_o(commit1_valid_o),
    .commit0_wen_o(commit0_wen_o), .commit1_wen_o(commit1_wen_o),
    .commit0_rd_o(commit0_rd_o), .commit1_rd_o(commit1_rd_o),
    .commit0_value_o(commit0_value_o), .commit1_value_o(commit1_value_o),
    .commit0_sid_o(commit0_sid_o), .commit1_sid_o(commit1_sid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        sid;
    bit        wen;
    bit [4:0]  rd;
    bit        done;
    bit [63:0] value;
  } m_entry_t;

  typedef struct {
    int        cyc;
    int        slot;
    int        sid;
    bit        wen;
    bit [4:0]  rd;
    bit [63:0] value;
  } exp_t;

  m_entry_t mq[$];
  exp_t     exp_q[$];
  int m_head = 0, m_tail = 0, cycle = 0;
  int n_compared = 0, n_mismatch = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  function automatic bit modelReady();
    return (DEPTH - mq.size()) >= 2;
  endfunction

  function automatic bit [31:0] modelBusy();
    bit [31:0] b = '0;
    foreach (mq[i]) if (mq[i].wen) b[mq[i].rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic int findPending(input int sid);
    foreach (mq[i]) if (mq[i].sid == sid && !mq[i].done) return i;
    return -1;
  endfunction

  function automatic int nthPending(input int n);
    int k = 0;
    foreach (mq[i]) if (!mq[i].done) begin
      if (k == n) return i;
      k++;
    end
    return -1;
  endfunction

  // Program-order list of in-flight instructions; retirement is the done prefix of the list.
  task automatic modelStep();
    bit   ready;
    int   nc, i0, i1;
    exp_t e;
    cycle++;
    ready = modelReady();
    if (flush_i) begin
      mq.delete();
      m_tail = m_head;
      return;
    end
    nc = 0;
    for (int s = 0; s < 2; s++) begin
      if (nc == s && mq.size() > s && mq[s].done) begin
        e = '{cyc: cycle, slot: s, sid: mq[s].sid, wen: mq[s].wen && mq[s].rd != 0,
              rd: mq[s].rd, value: mq[s].value};
        exp_q.push_back(e);
        nc++;
      end
    end
    i0 = inst0_wb_valid_i ? findPending(int'(inst0_wb_sid_i)) : -1;
    i1 = inst1_wb_valid_i ? findPending(int'(inst1_wb_sid_i)) : -1;
    if (i0 >= 0) begin mq[i0].done = 1; mq[i0].value = inst0_wb_value_i; end
    if (i1 >= 0) begin mq[i1].done = 1; mq[i1].value = inst1_wb_value_i; end
    repeat (nc) void'(mq.pop_front());
    m_head = (m_head + nc) % SIDS;
    if (ready) begin
      if (issue0_valid_i) begin
        mq.push_back('{sid: m_tail, wen: issue0_wen_i, rd: issue0_rd_i, done: 0, value: 0});
        m_tail = (m_tail + 1) % SIDS;
      end
      if (issue1_valid_i) begin
        mq.push_back('{sid: m_tail, wen: issue1_wen_i, rd: issue1_rd_i, done: 0, value: 0});
        m_tail = (m_tail + 1) % SIDS;
      end
    end
  endtask

  task automatic idleInputs();
    issue0_valid_i = 0; issue1_valid_i = 0; issue0_wen_i = 0; issue1_wen_i = 0;
    issue0_rd_i = '0; issue1_rd_i = '0;
    inst0_wb_valid_i = 0; inst1_wb_valid_i = 0; inst0_wb_sid_i = '0; inst1_wb_sid_i = '0;
    inst0_wb_value_i = '0; inst1_wb_value_i = '0; flush_i = 0;
  endtask

  task automatic setIssue(input bit v0, input bit [4:0] rd0, input bit w0,
                          input bit v1, input bit [4:0] rd1, input bit w1);
    issue0_valid_i = v0; issue0_rd_i = rd0; issue0_wen_i = w0;
    issue1_valid_i = v1; issue1_rd_i = rd1; issue1_wen_i = w1;
  endtask

  task automatic setWb(input int port, input int sid, input bit [63:0] val);
    if (port == 0) begin
      inst0_wb_valid_i = 1; inst0_wb_sid_i = SW'(sid); inst0_wb_value_i = val;
    end else begin
      inst1_wb_valid_i = 1; inst1_wb_sid_i = SW'(sid); inst1_wb_value_i = val;
    end
  endtask

  task automatic checkOutput();
    check("alloc_ready", 64'(alloc_ready_o), 64'(modelReady()));
    check("rd_busy", 64'(rd_busy_o), 64'(modelBusy()));
  endtask

  // One clock: check combinational sids, clock the DUT and the model, then check registered state.
  task automatic applyStimulus();
    #1;
    if (modelReady()) begin
      if (issue0_valid_i) check("issue0_sid", 64'(issue0_sid_o), 64'(m_tail));
      if (issue1_valid_i)
        check("issue1_sid", 64'(issue1_sid_o), 64'(issue0_valid_i ? (m_tail + 1) % SIDS : m_tail));
    end
    @(posedge clk);
    modelStep();
    @(negedge clk);
    idleInputs();
    checkOutput();
  endtask

  // Decoupled commit checker: every DUT retire strobe must match the oldest predicted retirement.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        logic        v;
        logic [63:0] got_val;
        int          got_sid, got_rd;
        logic        got_wen;
        bit          present;
        v       = s == 0 ? commit0_valid_o : commit1_valid_o;
        got_val = s == 0 ? commit0_value_o : commit1_value_o;
        got_sid = s == 0 ? int'(commit0_sid_o) : int'(commit1_sid_o);
        got_rd  = s == 0 ? int'(commit0_rd_o) : int'(commit1_rd_o);
        got_wen = s == 0 ? commit0_wen_o : commit1_wen_o;
        present = exp_q.size() > 0 && exp_q[0].cyc == cycle && exp_q[0].slot == s;
        if (v || present) begin
          n_compared++;
          if (!present) begin
            n_mismatch++;
            $display("[TB] FAIL commit%0d_unexpected: got sid %0d rd %0d value 0x%0h, expected no commit",
                     s, got_sid, got_rd, got_val);
          end else if (!v) begin
            n_mismatch++;
            $display("[TB] FAIL commit%0d_missing: got no commit, expected sid %0d value 0x%0h at cycle %0d",
                     s, exp_q[0].sid, exp_q[0].value, cycle);
            void'(exp_q.pop_front());
          end else begin
            if (got_sid != exp_q[0].sid || got_rd != int'(exp_q[0].rd) ||
                got_wen !== exp_q[0].wen || got_val !== exp_q[0].value) begin
              n_mismatch++;
              $display("[TB] FAIL commit%0d_fields: got sid %0d rd %0d wen %0d value 0x%0h, expected sid %0d rd %0d wen %0d value 0x%0h",
                       s, got_sid, got_rd, got_wen, got_val,
                       exp_q[0].sid, exp_q[0].rd, exp_q[0].wen, exp_q[0].value);
            end
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int sid0, sid1, old_head, freed, p;
    idleInputs();
    #12;
    @(negedge clk);
    rst_n = 1;
    check("reset_alloc_ready", 64'(alloc_ready_o), 64'd1);
    check("reset_rd_busy", 64'(rd_busy_o), 64'd0);
    check("reset_commit_valids", 64'({commit0_valid_o, commit1_valid_o}), 64'd0);
    check("reset_issue_sids", 64'({issue0_sid_o, issue1_sid_o}), 64'd0);

    setIssue(1, 5, 1, 1, 6, 1);
    applyStimulus();
    check("busy_x5_x6", 64'(rd_busy_o), 64'h60);

    setWb(0, 1, 64'hBB); applyStimulus();
    applyStimulus();
    setWb(1, 0, 64'hAA); applyStimulus();
    applyStimulus();
    applyStimulus();
    check("busy_cleared", 64'(rd_busy_o), 64'd0);

    for (int k = 0; k < 3; k++) begin
      setIssue(1, 5'(k + 1), 1, 1, 5'(k + 10), 1);
      applyStimulus();
    end
    setIssue(1, 20, 1, 0, 0, 0); applyStimulus();
    check("full_not_ready", 64'(alloc_ready_o), 64'd0);
    setIssue(1, 21, 1, 1, 22, 1); applyStimulus();
    setWb(0, mq[0].sid, 64'h1234); applyStimulus();
    applyStimulus();
    check("ready_after_commit", 64'(alloc_ready_o), 64'd1);
    for (int k = 0; k < 10 && mq.size() > 0; k++) begin
      p = nthPending(0); if (p >= 0) setWb(0, mq[p].sid, {$urandom, $urandom});
      p = nthPending(1); if (p >= 0) setWb(1, mq[p].sid, {$urandom, $urandom});
      applyStimulus();
    end
    applyStimulus(); applyStimulus();

    for (int r = 0; r < 20; r++) begin
      setIssue(1, 5'($urandom_range(0, 31)), 1'($urandom), 1, 5'($urandom_range(0, 31)), 1'($urandom));
      applyStimulus();
      sid0 = mq[mq.size() - 2].sid;
      sid1 = mq[mq.size() - 1].sid;
      if ($urandom_range(0, 1) == 1) begin
        setWb(0, sid1, {$urandom, $urandom}); setWb(1, sid0, {$urandom, $urandom});
      end else begin
        setWb(1, sid1, {$urandom, $urandom}); setWb(0, sid0, {$urandom, $urandom});
      end
      applyStimulus();
    end
    applyStimulus(); applyStimulus();

    setIssue(1, 7, 1, 1, 8, 1); applyStimulus();
    sid0 = mq[0].sid;
    sid1 = mq[1].sid;
    setWb(0, sid0, 64'h1); setWb(1, sid0, 64'h2); applyStimulus();
    setWb(0, sid1, 64'h3); applyStimulus();
    applyStimulus(); applyStimulus();
    setWb(0, sid0, 64'hDEAD); setWb(1, sid1, 64'hBEEF); applyStimulus();
    applyStimulus(); applyStimulus();

    setIssue(1, 3, 1, 1, 4, 1); applyStimulus();
    setIssue(1, 9, 1, 1, 0, 1); applyStimulus();
    old_head = m_head;
    flush_i = 1;
    setWb(0, mq[0].sid, 64'h55);
    setIssue(1, 11, 1, 0, 0, 0);
    applyStimulus();
    check("flush_busy", 64'(rd_busy_o), 64'd0);
    setIssue(1, 12, 1, 0, 0, 0);
    #1 check("flush_next_sid", 64'(issue0_sid_o), 64'(old_head));
    applyStimulus();

    setIssue(1, 13, 1, 1, 14, 1); applyStimulus();
    setWb(1, mq[0].sid, 64'h77); applyStimulus();
    #2 rst_n = 0;
    #1;
    check("midreset_commits", 64'({commit0_valid_o, commit1_valid_o, commit0_wen_o, commit1_wen_o}), 64'd0);
    check("midreset_values", commit0_value_o | commit1_value_o, 64'd0);
    check("midreset_busy", 64'(rd_busy_o), 64'd0);
    mq.delete(); exp_q.delete(); m_head = 0; m_tail = 0;
    @(negedge clk);
    rst_n = 1;
    checkOutput();

    for (int k = 0; k < 300; k++) begin
      setIssue(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom),
               1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), 1'($urandom));
      for (int port = 0; port < 2; port++) begin
        if ($urandom_range(0, 2) != 0) begin
          p = nthPending($urandom_range(0, 2));
          freed = (p >= 0 && $urandom_range(0, 4) != 0) ? mq[p].sid : $urandom_range(0, SIDS - 1);
          setWb(port, freed, {$urandom, $urandom});
        end
      end
      flush_i = ($urandom_range(0, 39) == 0);
      applyStimulus();
    end

    for (int k = 0; k < 40 && mq.size() > 0; k++) begin
      p = nthPending(0); if (p >= 0) setWb(0, mq[p].sid, {$urandom, $urandom});
      p = nthPending(1); if (p >= 0) setWb(1, mq[p].sid, {$urandom, $urandom});
      applyStimulus();
    end
    applyStimulus(); applyStimulus(); applyStimulus();
    check("drained_model", 64'(mq.size()), 64'd0);
    check("drained_expected_commits", 64'(exp_q.size()), 64'd0);
    check("drained_ready", 64'(alloc_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
